// File: rtl/shift_pkg.sv
// Shared shift-arbiter types: op encoding, FSM states, request bundle, bit-reverse helper.
// Pure declarations; no latency or backpressure of its own.
package shift_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic [1:0] {
    OP_SRL = 2'd0,
    OP_SLL = 2'd1,
    OP_SRA = 2'd2,
    OP_RSV = 2'd3
  } shift_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    shift_op_e          op;
    logic [DATA_W-1:0]  a;
    logic [AMT_W-1:0]   amt;
  } shift_req_t;

  function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = x[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter.sv
// Single 32-bit logical right-shift core shared by every shift op.
// Combinational, zero latency; no backpressure.
module shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] inA,
  input  logic [AMT_W-1:0]  inB,
  input  logic              en,
  output logic [DATA_W-1:0] out
);

  assign out = en ? (inA >> inB) : '0;

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin shift unit with one output register; SHIFT_ARB_CNT_EN adds stall counters.
// One cycle accept-to-response; req ready drops while a held result waits on its owner's rsp ready.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [1:0]        i_req_op0,
  input  logic [1:0]        i_req_op1,
  input  logic [DATA_W-1:0] i_req_a0,
  input  logic [DATA_W-1:0] i_req_a1,
  input  logic [AMT_W-1:0]  i_req_amt0,
  input  logic [AMT_W-1:0]  i_req_amt1,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data
`ifdef SHIFT_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_stall_cnt0,
  output logic [CNT_W-1:0]  o_stall_cnt1
`endif
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              rsp_fire;
  logic              can_accept;
  logic              grant;
  logic              accept;
  shift_req_t        req0, req1, sel;
  logic [DATA_W-1:0] core_in, core_out, result;

  assign req0 = '{op: shift_op_e'(i_req_op0), a: i_req_a0, amt: i_req_amt0};
  assign req1 = '{op: shift_op_e'(i_req_op1), a: i_req_a1, amt: i_req_amt1};

  // Ties go to whoever was not granted last; a lone valid always wins.
  always_comb begin
    rsp_fire   = (state_q == ST_HOLD) && i_rsp_ready[owner_q];
    can_accept = (state_q == ST_IDLE) || rsp_fire;
    grant      = (&i_req_valid) ? ~last_q : i_req_valid[1];
    accept     = can_accept && (|i_req_valid) && i_rst_n;
    sel        = grant ? req1 : req0;
  end

  assign o_req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  // SLL and SRA are folded onto the right-shift core by pre/post transforms.
  always_comb begin
    core_in = sel.a;
    case (sel.op)
      OP_SLL:  core_in = bitrev(sel.a);
      OP_SRA:  core_in = sel.a[DATA_W-1] ? ~sel.a : sel.a;
      default: core_in = sel.a;
    endcase
  end

  shifter u_shifter (
    .inA (core_in),
    .inB (sel.amt),
    .en  (1'b1),
    .out (core_out)
  );

  always_comb begin
    result = core_out;
    case (sel.op)
      OP_SLL:  result = bitrev(core_out);
      OP_SRA:  result = sel.a[DATA_W-1] ? ~core_out : core_out;
      default: result = core_out;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (accept)        state_d = ST_HOLD;
        else if (rsp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      owner_d = grant;
      last_d  = grant;
      data_d  = result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign o_rsp_valid = (state_q == ST_HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = data_q;

`ifdef SHIFT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Saturating: a stuck requester pins at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (i_req_valid[0] && !o_req_ready[0] && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (i_req_valid[1] && !o_req_ready[1] && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign o_stall_cnt0 = cnt0_q;
  assign o_stall_cnt1 = cnt1_q;
`else
  // Counter-free build: the stall counters and their ports do not exist.
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_shift_arbiter;

  localparam int CW = 4;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  op0, op1;
  logic [31:0] a0, a1;
  logic [4:0]  amt0, amt1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
`ifdef SHIFT_ARB_CNT_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  shift_arbiter #(.CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_op0   (op0),
    .i_req_op1   (op1),
    .i_req_a0    (a0),
    .i_req_a1    (a1),
    .i_req_amt0  (amt0),
    .i_req_amt1  (amt1),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data)
`ifdef SHIFT_ARB_CNT_EN
    ,
    .o_stall_cnt0 (cnt0),
    .o_stall_cnt1 (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the unit is holding, for whom, and who won last.
  logic        m_hold;
  logic        m_owner;
  logic        m_last;
  logic [31:0] m_data;
  int          m_cnt [2];
  logic [1:0]  seen_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
    case (op)
      2'd1:    return a << amt;
      2'd2:    return $unsigned($signed(a) >>> amt);
      default: return a >> amt;
    endcase
  endfunction

  task automatic check_regs();
    check("rsp_valid", {30'd0, rsp_valid}, m_hold ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
    if (m_hold) check("rsp_data", rsp_data, m_data);
`ifdef SHIFT_ARB_CNT_EN
    check("stall_cnt0", {28'd0, cnt0}, m_cnt[0]);
    check("stall_cnt1", {28'd0, cnt1}, m_cnt[1]);
`endif
  endtask

  task automatic cycle(input logic [1:0] v, input logic [1:0] rr,
                       input logic [1:0] o0, input logic [31:0] x0, input logic [4:0] s0,
                       input logic [1:0] o1, input logic [31:0] x1, input logic [4:0] s1);
    logic       fire, can, g, acc;
    logic [1:0] exp_rdy;
    @(negedge clk);
    check_regs();
    rst_n = 1'b1;
    req_valid = v; rsp_ready = rr;
    op0 = o0; a0 = x0; amt0 = s0;
    op1 = o1; a1 = x1; amt1 = s1;
    fire    = m_hold && rr[m_owner];
    can     = !m_hold || fire;
    g       = (v == 2'b11) ? !m_last : v[1];
    acc     = can && (v != 2'b00);
    exp_rdy = acc ? (g ? 2'b10 : 2'b01) : 2'b00;
    #1;
    seen_ready = req_ready;
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      if (v[i] && !exp_rdy[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
    if (acc) begin
      m_hold = 1'b1; m_owner = g; m_last = g;
      m_data = g ? ref_shift(o1, x1, s1) : ref_shift(o0, x0, s0);
    end else if (fire) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic rst_cycle(input logic [1:0] v);
    @(negedge clk);
    check_regs();
    rst_n = 1'b0; req_valid = v; rsp_ready = 2'b11;
    #1;
    check("ready_in_reset", {30'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    m_hold = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    check("rst_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_data", rsp_data, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    op0 = 2'd0; op1 = 2'd0; a0 = '0; a1 = '0; amt0 = '0; amt1 = '0;
    m_hold = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_data = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; seen_ready = 2'b00;

    rst_cycle(2'b11);
    rst_cycle(2'b01);

    // req0 SRL of the sign bit by 4
    cycle(2'b01, 2'b11, 2'd0, 32'h8000_0000, 5'd4, 2'd0, 32'h0, 5'd0);
    check("srl_valid", {30'd0, rsp_valid}, 32'd1);
    check("srl_data", rsp_data, 32'h0800_0000);
    // req1 SRA and SLL back to back
    cycle(2'b10, 2'b11, 2'd0, 32'h0, 5'd0, 2'd2, 32'h8000_0000, 5'd4);
    check("sra_data", rsp_data, 32'hF800_0000);
    cycle(2'b10, 2'b11, 2'd0, 32'h0, 5'd0, 2'd1, 32'h0000_0001, 5'd31);
    check("sll_data", rsp_data, 32'h8000_0000);
    check("sll_valid", {30'd0, rsp_valid}, 32'd2);

    // Four-cycle tie: grants alternate 0,1,0,1 at full rate
    for (int i = 0; i < 4; i++) begin
      cycle(2'b11, 2'b11, 2'd0, 32'h1000_0000 + i, 5'(i + 1), 2'd1, 32'h0000_0100 + i, 5'(i + 2));
      check("tie_grant", {30'd0, seen_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check("tie_rsp_data", rsp_data, (i % 2 == 0) ? ((32'h1000_0000 + i) >> (i + 1))
                                                    : ((32'h0000_0100 + i) << (i + 2)));
    end

    // Owner (req1) stalls three cycles; non-owner ready must not release it
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, 2'b01, 2'd1, $urandom, 5'd3, 2'd2, $urandom, 5'd7);
      check("stall_no_ready", {30'd0, seen_ready}, 32'd0);
      check("stall_data_stable", rsp_data, (32'h0000_0103) << 5);
    end

    // Boundary ops: amt=0, SRA by 31 of a negative value, reserved op as SRL
    cycle(2'b01, 2'b10, 2'd1, 32'h1234_5678, 5'd0, 2'd0, 32'h0, 5'd0);
    check("amt0_sll", rsp_data, 32'h1234_5678);
    cycle(2'b01, 2'b01, 2'd2, 32'h8000_0001, 5'd31, 2'd0, 32'h0, 5'd0);
    check("sra31_neg", rsp_data, 32'hFFFF_FFFF);
    cycle(2'b10, 2'b01, 2'd0, 32'h0, 5'd0, 2'd3, 32'hF000_0000, 5'd4);
    check("op3_as_srl", rsp_data, 32'h0F00_0000);
    cycle(2'b01, 2'b00, 2'd2, 32'h8765_4321, 5'd0, 2'd0, 32'h0, 5'd0);

    // Reset while holding: result is dropped and the next tie goes to req0
    rst_cycle(2'b11);
    cycle(2'b11, 2'b11, 2'd0, 32'hAAAA_5555, 5'd1, 2'd1, 32'h5555_AAAA, 5'd1);
    check("post_rst_tie", {30'd0, seen_ready}, 32'd1);
    cycle(2'b00, 2'b11, 2'd0, 32'h0, 5'd0, 2'd0, 32'h0, 5'd0);

`ifdef SHIFT_ARB_CNT_EN
    rst_cycle(2'b00);
    cycle(2'b01, 2'b00, 2'd0, 32'h1, 5'd0, 2'd0, 32'h0, 5'd0);
    for (int i = 0; i < 20; i++)
      cycle(2'b10, 2'b00, 2'd0, 32'h0, 5'd0, 2'd1, 32'h2, 5'd1);
    check("cnt1_saturated", {28'd0, cnt1}, 32'd15);
    check("cnt0_idle", {28'd0, cnt0}, 32'd0);
`endif

    // Randomized traffic, with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        rst_cycle(2'($urandom));
      end else begin
        cycle(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
              2'($urandom), $urandom, 5'($urandom),
              2'($urandom), $urandom, 5'($urandom));
      end
    end
    @(negedge clk);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
